chip8_call_ret_ctrl: RTL and testbench
======================================

Name: chip8_call_ret_ctrl

Overview:
Call/return sequencer on the CPU side of the Chip-8 subroutine stack. It takes CALL (2nnn) and RET (00EE) requests from the instruction decoder and drives the stack's push/pop write-enable and PC data. For RET it captures the popped return address. It then hands the new PC back to the fetch stage with a load strobe, and it tracks stack depth to flag overflow and underflow.

Parameters:
DEPTH, 16, number of stack entries; depth counter saturation limit
ADDR_W, 12, width of the CALL target address field (nnn)
PC_W, 16, program counter and stack data width
RET_INC, 2, byte offset added to the current PC to form the pushed return address

Ports:
cpu_clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
call_req  in  1  decoder requests a CALL; sampled in IDLE only
ret_req  in  1  decoder requests a RET; sampled in IDLE only
cur_pc  in  PC_W  PC of the CALL instruction, sampled with call_req
call_addr  in  ADDR_W  CALL target nnn, sampled with call_req
clear_fault  in  1  clears sticky fault flags
stk_we  out  2  stack command: 00 idle, 01 push, 10 pop; 11 never driven
stk_writedata  out  PC_W  return address for push
stk_outdata  in  PC_W  stack read data; valid on the edge after a pop cycle
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
pc_load  out  1  one-cycle strobe; fetch loads pc_next
pc_next  out  PC_W  new PC
depth  out  log2(DEPTH)+1  current number of live entries
fault_ovf  out  1  sticky: CALL attempted with depth==DEPTH
fault_unf  out  1  sticky: RET attempted with depth==0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - stk_we=00, stk_writedata=0, busy=0, done=0, pc_load=0, pc_next=0, depth=0, fault_ovf=0, fault_unf=0.
  - Reset mid-sequence aborts it immediately; no partial stack command survives.
- All outputs are registered.
- States: IDLE, PUSH, POP, CAPT, DONE.
- IDLE, call_req=1 (wins over ret_req when both are high):
  - If depth==DEPTH: set fault_ovf and go to DONE with no stack op and no pc_load.
  - Otherwise latch tgt={zeros,call_addr} and set stk_writedata=cur_pc+RET_INC, modulo 2^PC_W.
  - Go to PUSH.
- IDLE, ret_req=1 only:
  - If depth==0: set fault_unf and go to DONE with no stack op and no pc_load.
  - Otherwise go to POP.
- PUSH: stk_we=01 for exactly one cycle; depth+1; next state DONE with pc_next=tgt and pc_load=1.
- POP: stk_we=10 for exactly one cycle; depth-1; next state CAPT.
- CAPT: pc_next<=stk_outdata; next state DONE with pc_load=1.
- DONE: done=1 for one cycle, plus pc_load=1 on non-fault paths; next state IDLE.
- busy: 1 in PUSH, POP, CAPT and DONE; 0 in IDLE.
- Requests are ignored whenever state!=IDLE, i.e. while busy. The decoder holds a request until done.
- Latency, counted from the request-sampling edge:
  - CALL: stk_we=01 in cycle+1, done/pc_load in cycle+2.
  - RET: stk_we=10 in cycle+1, done/pc_load in cycle+3.
  - Fault: done in cycle+1.
- A request held high through done is re-accepted in the IDLE cycle after DONE. Back-to-back throughput is therefore 1 CALL per 3 cycles and 1 RET per 4 cycles.
- depth never wraps; it stays in 0..DEPTH.
- pc_next holds its value between loads.
- Faults:
  - fault flags stay set until clear_fault=1 or reset.
  - clear_fault has lower priority than a same-cycle new fault set.
  - A fault leaves depth and pc_next unchanged.

Test Plan:
- Reset: reset_n=0 mid-PUSH -> stk_we=00, depth=0, busy=0 asynchronously; no pc_load after release.
- CALL: cur_pc=0x0200, call_addr=0x345 -> PUSH cycle with stk_we=01 and stk_writedata=0x0202; 2 cycles after the sampling edge pc_next=0x0345, pc_load=1, done=1; depth=1.
- CALL then RET: after the previous case, ret_req with stub stack returning 0x0202 -> POP cycle stk_we=10; 3 cycles after the sampling edge pc_next=0x0202, pc_load=1; depth=0.
- Overflow: 16 CALLs, then a 17th -> fault_ovf=1, done=1, pc_load=0, stk_we stays 00, depth=16; clear_fault -> fault_ovf=0.
- Underflow: RET at depth=0 -> fault_unf=1, done one cycle after sampling, no stack op; then call_req and ret_req together -> CALL wins.
- Wrap and busy: cur_pc=0xFFFF -> stk_writedata=0x0001; ret_req pulsed while busy -> ignored, only one stk_we pulse seen.

Source files
------------

// File: rtl/chip8_call_ret_ctrl.sv
// chip8_call_ret_ctrl: CALL/RET sequencer driving the Chip-8 subroutine stack and the fetch PC load
module chip8_call_ret_ctrl #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 12,
  parameter int PC_W    = 16,
  parameter int RET_INC = 2,
  localparam int DW     = $clog2(DEPTH) + 1
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [PC_W-1:0]   cur_pc,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              clear_fault,
  output logic [1:0]        stk_we,
  output logic [PC_W-1:0]   stk_writedata,
  input  logic [PC_W-1:0]   stk_outdata,
  output logic              busy,
  output logic              done,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_next,
  output logic [DW-1:0]     depth,
  output logic              fault_ovf,
  output logic              fault_unf
);
  typedef enum logic [2:0] {IDLE, PUSH, POP, CAPT, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        stk_we_q, stk_we_d;
  logic [PC_W-1:0]   wd_q, wd_d, tgt_q, tgt_d, pc_next_q, pc_next_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              busy_q, done_q, done_d, pc_load_q, pc_load_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  // next-state and registered-output computation; stack commands are issued one cycle ahead of their state
  always_comb begin
    state_d   = state_q;
    stk_we_d  = 2'b00;
    wd_d      = wd_q;
    tgt_d     = tgt_q;
    done_d    = 1'b0;
    pc_load_d = 1'b0;
    pc_next_d = pc_next_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q & ~clear_fault;
    unf_d     = unf_q & ~clear_fault;
    case (state_q)
      IDLE: begin
        if (call_req) begin
          if (depth_q == DW'(DEPTH)) begin
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            tgt_d    = {{(PC_W-ADDR_W){1'b0}}, call_addr};
            wd_d     = cur_pc + PC_W'(RET_INC);
            stk_we_d = 2'b01;
            state_d  = PUSH;
          end
        end else if (ret_req) begin
          if (depth_q == '0) begin
            unf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            stk_we_d = 2'b10;
            state_d  = POP;
          end
        end
      end
      PUSH: begin
        depth_d   = depth_q + 1'b1;
        pc_next_d = tgt_q;
        pc_load_d = 1'b1;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      POP: begin
        depth_d = depth_q - 1'b1;
        state_d = CAPT;
      end
      CAPT: begin
        pc_next_d = stk_outdata;
        pc_load_d = 1'b1;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; async reset aborts any sequence in flight
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      stk_we_q  <= 2'b00;
      wd_q      <= '0;
      tgt_q     <= '0;
      pc_next_q <= '0;
      depth_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stk_we_q  <= stk_we_d;
      wd_q      <= wd_d;
      tgt_q     <= tgt_d;
      pc_next_q <= pc_next_d;
      depth_q   <= depth_d;
      busy_q    <= state_d != IDLE;
      done_q    <= done_d;
      pc_load_q <= pc_load_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
  assign stk_we        = stk_we_q;
  assign stk_writedata = wd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pc_load       = pc_load_q;
  assign pc_next       = pc_next_q;
  assign depth         = depth_q;
  assign fault_ovf     = ovf_q;
  assign fault_unf     = unf_q;
endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// tb_chip8_call_ret_ctrl: directed self-checking bench with a behavioural stack stub
module tb_chip8_call_ret_ctrl;
  logic        cpu_clk = 1'b0, reset_n = 1'b0;
  logic        call_req = 1'b0, ret_req = 1'b0, clear_fault = 1'b0;
  logic [15:0] cur_pc = '0, stk_writedata, stk_outdata, pc_next;
  logic [11:0] call_addr = '0;
  logic [1:0]  stk_we;
  logic        busy, done, pc_load, fault_ovf, fault_unf;
  logic [4:0]  depth;
  logic [15:0] mem [0:15];
  logic [4:0]  sp;
  int          n_cmp = 0, n_err = 0, n_push = 0;

  chip8_call_ret_ctrl dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .call_req(call_req), .ret_req(ret_req),
    .cur_pc(cur_pc), .call_addr(call_addr), .clear_fault(clear_fault),
    .stk_we(stk_we), .stk_writedata(stk_writedata), .stk_outdata(stk_outdata),
    .busy(busy), .done(done), .pc_load(pc_load), .pc_next(pc_next),
    .depth(depth), .fault_ovf(fault_ovf), .fault_unf(fault_unf)
  );

  always #5 cpu_clk = ~cpu_clk;

  // stack stub: read data appears on the edge after the pop cycle
  always @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      sp          <= '0;
      stk_outdata <= '0;
    end else if (stk_we == 2'b01) begin
      mem[sp[3:0]] <= stk_writedata;
      sp           <= sp + 1'b1;
      n_push       <= n_push + 1;
    end else if (stk_we == 2'b10) begin
      stk_outdata <= mem[sp[3:0] - 4'd1];
      sp          <= sp - 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_call(input logic [15:0] pc, input logic [11:0] a);
    cur_pc = pc; call_addr = a; call_req = 1'b1;
    tick();
    call_req = 1'b0;
    tick();
    chk("call_pc", pc_next, {4'h0, a});
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_we", stk_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pcl", pc_load, 0);
    chk("rst_pcn", pc_next, 0);
    chk("rst_depth", depth, 0);
    chk("rst_flt", {fault_ovf, fault_unf}, 0);
    reset_n = 1'b1;
    tick();

    cur_pc = 16'h0200; call_addr = 12'h345; call_req = 1'b1;
    tick();
    call_req = 1'b0;
    chk("call_we", stk_we, 1);
    chk("call_wd", stk_writedata, 16'h0202);
    chk("call_busy", busy, 1);
    chk("call_early_done", done, 0);
    tick();
    chk("call_done", done, 1);
    chk("call_pcl", pc_load, 1);
    chk("call_pcn", pc_next, 16'h0345);
    chk("call_depth", depth, 1);
    chk("call_we_off", stk_we, 0);
    tick();
    chk("call_idle", {busy, done, pc_load}, 0);

    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    chk("ret_we", stk_we, 2);
    tick();
    chk("ret_capt_we", stk_we, 0);
    chk("ret_capt_done", done, 0);
    chk("ret_depth", depth, 0);
    tick();
    chk("ret_done", done, 1);
    chk("ret_pcl", pc_load, 1);
    chk("ret_pcn", pc_next, 16'h0202);
    tick();
    chk("ret_idle", busy, 0);

    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    chk("unf_flag", fault_unf, 1);
    chk("unf_done", done, 1);
    chk("unf_pcl", pc_load, 0);
    chk("unf_we", stk_we, 0);
    chk("unf_pcn", pc_next, 16'h0202);
    chk("unf_depth", depth, 0);
    tick();
    chk("unf_done_off", done, 0);
    chk("unf_sticky", fault_unf, 1);

    cur_pc = 16'h0300; call_addr = 12'h123; call_req = 1'b1; ret_req = 1'b1;
    tick();
    call_req = 1'b0; ret_req = 1'b0;
    chk("both_we", stk_we, 1);
    tick();
    chk("both_pcn", pc_next, 16'h0123);
    chk("both_depth", depth, 1);
    tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("unf_clr", fault_unf, 0);

    for (int i = 1; i < 16; i++) do_call(16'h0400 + 16'(2 * i), 12'h500 + 12'(i));
    chk("full_depth", depth, 16);
    cur_pc = 16'h0600; call_addr = 12'h777; call_req = 1'b1;
    tick();
    call_req = 1'b0;
    chk("ovf_flag", fault_ovf, 1);
    chk("ovf_done", done, 1);
    chk("ovf_pcl", pc_load, 0);
    chk("ovf_we", stk_we, 0);
    chk("ovf_depth", depth, 16);
    chk("ovf_pcn", pc_next, 16'h050F);
    tick();
    chk("ovf_we2", stk_we, 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("ovf_clr", fault_ovf, 0);

    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    tick(); tick();
    chk("ret15_pcn", pc_next, 16'h0420);
    chk("ret15_depth", depth, 15);
    tick();

    n_push = 0;
    cur_pc = 16'hFFFF; call_addr = 12'hABC; call_req = 1'b1;
    tick();
    call_req = 1'b0; ret_req = 1'b1;
    chk("wrap_wd", stk_writedata, 16'h0001);
    tick();
    ret_req = 1'b0;
    chk("wrap_pcn", pc_next, 16'h0ABC);
    chk("wrap_depth", depth, 16);
    tick();
    tick();
    chk("busy_ign_we", stk_we, 0);
    chk("busy_ign_busy", busy, 0);
    chk("busy_pushes", n_push, 1);

    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    tick(); tick(); tick();
    call_req = 1'b1; cur_pc = 16'h0700; call_addr = 12'h111;
    tick();
    call_req = 1'b0;
    chk("mid_we", stk_we, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_we", stk_we, 0);
    chk("arst_depth", depth, 0);
    chk("arst_busy", busy, 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("arst_pcl", pc_load, 0);
    tick();
    chk("arst_pcl2", pc_load, 0);
    chk("arst_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
